// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: default width, counter width and FSM encoding.
// Imported by the top and its datapath step.
package seq_divider_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_PREP = ST_PREP,
        S_RUN  = ST_RUN,
        S_FIX  = ST_FIX,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial remainder.
// Latency: combinational. Backpressure: none.
// Outputs the quotient bit and the remainder to keep for the next step.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   rem_sh,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             q_bit
);

    logic [WIDTH:0]   dext;
    logic [WIDTH-1:0] diff;

    assign dext  = {1'b0, dmag};
    assign q_bit = (rem_sh >= dext);
    // When the trial succeeds the true difference is below dmag, so WIDTH bits hold it exactly.
    assign diff    = rem_sh[WIDTH-1:0] - dmag;
    assign rem_nxt = q_bit ? diff : rem_sh[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider producing quotient and remainder, one bit per clock.
// Latency: WIDTH+2 edges from accepted start to done (3 edges for a zero divisor).
// Backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic             sgn_reg;
    logic [WIDTH-1:0] rem, q, dmag;
    logic             sign_q, sign_r, zflag;
    logic [CNT_W-1:0] cnt;

    logic             sa, sb;
    logic [WIDTH-1:0] amag, bmag;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    assign sa   = sgn_reg & a_reg[WIDTH-1];
    assign sb   = sgn_reg & b_reg[WIDTH-1];
    assign amag = sa ? (~a_reg + 1'b1) : a_reg;
    assign bmag = sb ? (~b_reg + 1'b1) : b_reg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_sh  ({rem, q[WIDTH-1]}),
        .dmag    (dmag),
        .rem_nxt (step_rem),
        .q_bit   (step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero divisor still passes through a single RUN slot (counter loaded with 0, no step),
    // which fixes its latency at three edges.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_PREP;
            S_PREP:  state_nxt = S_RUN;
            S_RUN:   if (cnt == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == S_PREP) || (state_nxt == S_RUN) || (state_nxt == S_FIX);
            done <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sgn_reg   <= 1'b0;
            rem       <= '0;
            q         <= '0;
            dmag      <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zflag     <= 1'b0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg   <= dividend;
                        b_reg   <= divisor;
                        sgn_reg <= is_signed;
                    end
                end
                S_PREP: begin
                    rem    <= '0;
                    q      <= amag;
                    dmag   <= bmag;
                    sign_q <= sa ^ sb;
                    sign_r <= sa;
                    zflag  <= (b_reg == '0);
                    cnt    <= (b_reg == '0) ? '0 : CNT_W'(WIDTH - 1);
                end
                S_RUN: begin
                    if (!zflag) begin
                        rem <= step_rem;
                        q   <= {q[WIDTH-2:0], step_bit};
                    end
                    cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    if (zflag) begin
                        quotient  <= '1;
                        remainder <= a_reg;
                        div_zero  <= 1'b1;
                    end else begin
                        // Remainder takes the dividend's sign: truncating division.
                        quotient  <= sign_q ? (~q + 1'b1) : q;
                        remainder <= sign_r ? (~rem + 1'b1) : rem;
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands against an arithmetic model.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_zero;
    logic [W-1:0] quotient, remainder;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: 64-bit integer division truncates toward zero, matching DIV/DIVU semantics.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint la, lb;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            la = s ? longint'($signed(a)) : longint'({32'b0, a});
            lb = s ? longint'($signed(b)) : longint'({32'b0, b});
            q  = W'(la / lb);
            r  = W'(la % lb);
            z  = 1'b0;
        end
    endfunction

    // kind 0: plain op; kind 1: re-pulse start at cycle 'at'; kind 2: assert reset at cycle 'at'.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int kind, input int at);
        logic [W-1:0] eq, er;
        logic         ez;
        int           lat;
        int           exp_lat;
        int           extra;
        bit           busy_ok;
        model(a, b, s, eq, er, ez);
        exp_lat = (b == '0) ? 3 : W + 2;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b; is_signed = s;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (kind == 2 && lat == at) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                check("rst_quot", 64'(quotient), 64'd0);
                check("rst_rem",  64'(remainder), 64'd0);
                check("rst_dz",   64'(div_zero), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (kind == 1 && lat == at) begin
                start = 1'b1; dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency",      64'(lat), 64'(exp_lat));
        check("busy_while",   64'(busy_ok), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        check("quotient",     64'(quotient), 64'(eq));
        check("remainder",    64'(remainder), 64'(er));
        check("div_zero",     64'(div_zero), 64'(ez));
        @(negedge clk);
        check("done_pulse",   64'(done), 64'd0);
        if (kind == 1) begin
            extra = 0;
            for (int i = 0; i < 45; i++) begin
                if (done) extra++;
                @(negedge clk);
            end
            check("single_done", 64'(extra), 64'd0);
            check("held_quot",   64'(quotient), 64'(eq));
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_quot", 64'(quotient), 64'd0);
        check("reset_rem",  64'(remainder), 64'd0);
        check("reset_dz",   64'(div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, 0, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0);
        run_op(32'h1234_5678, 32'd0, 1'b0, 0, 0);
        run_op(32'hFFFF_FFF0, 32'd0, 1'b1, 0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0);
        run_op(32'd5, 32'd9, 1'b0, 0, 0);
        run_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 1, 10);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(1, 15));
                1:       rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                2:       rb = -32'($urandom_range(1, 300));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(ra, rb, 1'($urandom), 0, 0);
        end

        run_op(32'h0BAD_F00D, 32'd17, 1'b0, 2, 15);
        run_op(32'd9, 32'd3, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
